alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/seq_regfile.sv | 32 +++
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer:
// opcodes, FSM states and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOTA = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_NONE = 4'hF;

  localparam int OP_LO  = 8;
  localparam int RD_LO  = 6;
  localparam int RS1_LO = 4;
  localparam int RS2_LO = 0;
  localparam int IMM_LO = 0;
  localparam int IW     = 12;

  function automatic logic is_alu_op(logic [3:0] op);
    return op <= OP_XNOR;
  endfunction

  function automatic logic is_legal_op(logic [3:0] op);
    return op <= OP_MOV;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Register file: two async read ports,
// one sync write port, cleared on reset.
module seq_regfile #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_a_i,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_a_o,
  output logic [DW-1:0] rd_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i
);

  logic [DW-1:0] mem_q [NREG];

  assign rd_a_o = mem_q[ra_a_i];
  assign rd_b_o = mem_q[ra_b_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer around an
// external ALU with a small register file.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [11:0]   instr,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [2:0]    res_flags,
  output logic          res_err,
  output logic [3:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_c,
  input  logic          alu_z,
  input  logic          alu_n
);

  localparam int AW = $clog2(NREG);

  state_e        state_q;
  logic [IW-1:0] instr_q;
  logic [DW-1:0] data_q;
  logic [2:0]    flags_q;
  logic          err_q;

  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [DW-1:0] imm;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [DW-1:0] wdata;
  logic          alu_op, legal, issue, we;

  assign op  = instr_q[OP_LO +: 4];
  assign rd  = instr_q[RD_LO +: AW];
  assign rs1 = instr_q[RS1_LO +: AW];
  assign rs2 = instr_q[RS2_LO +: AW];
  assign imm = DW'(instr_q[IMM_LO +: 4]);

  assign alu_op = is_alu_op(op);
  assign legal  = is_legal_op(op);
  assign issue  = (state_q == S_ISSUE);
  assign we     = issue && legal;

  seq_regfile #(
    .DW  (DW),
    .NREG(NREG)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra_a_i(rs1),
    .ra_b_i(rs2),
    .rd_a_o(rdata_a),
    .rd_b_o(rdata_b),
    .we_i  (we),
    .wa_i  (rd),
    .wd_i  (wdata)
  );

  // Illegal ops fall through to zero data.
  always_comb begin
    wdata = '0;
    unique case (1'b1)
      alu_op:         wdata = alu_y;
      (op == OP_LDI): wdata = imm;
      (op == OP_MOV): wdata = rdata_a;
      default:        wdata = '0;
    endcase
  end

  assign alu_sel = (issue && alu_op) ? op : OP_NONE;
  assign alu_a   = (issue && alu_op) ? rdata_a : '0;
  assign alu_b   = (issue && alu_op) ? rdata_b : '0;

  assign instr_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_RESP);
  assign res_data    = data_q;
  assign res_flags   = flags_q;
  assign res_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          data_q  <= wdata;
          err_q   <= !legal;
          if (alu_op) flags_q <= {alu_c, alu_z, alu_n};
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an
// external 4-bit ALU and a reference model.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [11:0] instr;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_flags;
  logic       res_err;
  logic [3:0] alu_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_y;
  logic       alu_c;
  logic       alu_z;
  logic       alu_n;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [3:0] m_reg [4];
  logic [2:0] m_flags;
  logic [3:0] exp_data;
  logic [2:0] exp_flags;
  logic       exp_err;
  logic [3:0] exp_sel, exp_a, exp_b;
  logic [3:0] last_data;
  logic [2:0] last_flags;
  logic       last_err;

  alu_sequencer #(.DW(4), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_err    (res_err),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
    .alu_c      (alu_c),
    .alu_z      (alu_z),
    .alu_n      (alu_n)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // External ALU: 4-bit select, flags C/Z/N.
  always_comb begin
    logic [4:0] wide;
    wide  = '0;
    alu_y = '0;
    alu_c = 1'b0;
    case (alu_sel)
      4'h0: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = wide[3:0]; alu_c = wide[4]; end
      4'h1: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_y = wide[3:0]; alu_c = wide[4]; end
      4'h2: alu_y = alu_a & alu_b;
      4'h3: alu_y = alu_a | alu_b;
      4'h4: alu_y = ~alu_a;
      4'h5: alu_y = ~(alu_a & alu_b);
      4'h6: alu_y = (alu_b >= 4) ? 4'h0 : alu_a << alu_b;
      4'h7: alu_y = (alu_b >= 4) ? 4'h0 : alu_a >> alu_b;
      4'h8: alu_y = alu_a ^ alu_b;
      4'h9: alu_y = ~(alu_a ^ alu_b);
      default: alu_y = '0;
    endcase
    alu_z = (alu_y == 4'h0);
    alu_n = alu_y[3];
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
    m_flags = 3'b000;
  endtask

  // Architectural effect of one instruction, from the opcode table.
  task automatic model(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [3:0] b);
    int a, bb, y, c;
    a  = m_reg[rs1];
    bb = m_reg[b[1:0]];
    y  = 0;
    c  = 0;
    exp_err = 1'b0;
    exp_sel = 4'hF;
    exp_a   = 4'h0;
    exp_b   = 4'h0;
    case (op)
      4'h0: begin y = a + bb; c = (y > 15); end
      4'h1: begin y = a - bb; c = (a < bb); end
      4'h2: y = a & bb;
      4'h3: y = a | bb;
      4'h4: y = 15 - a;
      4'h5: y = 15 - (a & bb);
      4'h6: y = (bb >= 4) ? 0 : a * (1 << bb);
      4'h7: y = (bb >= 4) ? 0 : a / (1 << bb);
      4'h8: y = a ^ bb;
      4'h9: y = 15 - (a ^ bb);
      4'hA: y = b;
      4'hB: y = a;
      default: exp_err = 1'b1;
    endcase
    y = y & 15;
    if (op <= 4'h9) begin
      m_flags = {c[0], (y == 0), (y >= 8)};
      exp_sel = op;
      exp_a   = a[3:0];
      exp_b   = bb[3:0];
    end
    if (!exp_err) m_reg[rd] = y[3:0];
    exp_data  = y[3:0];
    exp_flags = m_flags;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    check("ready_timeout", instr_ready, 1);
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [3:0] b,
                          input int hold, input bit rogue);
    logic [3:0] d0;
    logic [2:0] f0;
    logic       e0;
    wait_ready();
    model(op, rd, rs1, b);
    instr       = {op, rd, rs1, b};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("issue_valid", res_valid, 0);
    check("issue_ready", instr_ready, 0);
    check("issue_sel", alu_sel, exp_sel);
    check("issue_a", alu_a, exp_a);
    check("issue_b", alu_b, exp_b);
    @(posedge clk);
    #1;
    check("latency", res_valid, 1);
    d0 = res_data;
    f0 = res_flags;
    e0 = res_err;
    if (rogue) begin
      instr       = {4'hA, 2'd1, 2'd0, 4'hF};
      instr_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", res_valid, 1);
      check("bp_ready", instr_ready, 0);
      check("bp_data", res_data, d0);
      check("bp_flags", res_flags, f0);
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("done_valid", res_valid, 0);
    check("done_ready", instr_ready, 1);
    last_data  = d0;
    last_flags = f0;
    last_err   = e0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("one_hot", instr_ready & res_valid, 0);
      if (res_valid) begin
        check("cmp_data", res_data, exp_data);
        check("cmp_flags", res_flags, exp_flags);
        check("cmp_err", res_err, exp_err);
      end
      if (instr_ready || res_valid) begin
        check("cmp_sel", alu_sel, 4'hF);
        check("cmp_ab", {alu_a, alu_b}, 8'h00);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    res_ready   = 1'b0;
    instr       = '0;
    model_reset();
    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_flags", res_flags, 3'b000);
    check("rst_sel", alu_sel, 4'hF);
    check("rst_data", res_data, 0);
    check("rst_err", res_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_instr(4'hA, 2'd1, 2'd0, 4'd5, 0, 0);
    check("ldi_r1", last_data, 5);
    do_instr(4'hA, 2'd2, 2'd0, 4'd12, 0, 0);
    check("ldi_r2", last_data, 12);
    do_instr(4'h0, 2'd3, 2'd1, 4'd2, 0, 0);
    check("add_data", last_data, 1);
    check("add_flags", last_flags, 3'b100);

    do_instr(4'h1, 2'd0, 2'd1, 4'd2, 0, 0);
    check("sub_data", last_data, 9);
    check("sub_flags", last_flags, 3'b101);
    do_instr(4'h2, 2'd0, 2'd1, 4'd2, 0, 0);
    check("and_data", last_data, 4);
    check("and_z", last_flags[1], 0);
    do_instr(4'h1, 2'd3, 2'd1, 4'd2, 0, 0);
    do_instr(4'hA, 2'd0, 2'd0, 4'd7, 0, 0);
    check("ldi_data", last_data, 7);
    check("ldi_keep", last_flags, 3'b101);

    do_instr(4'h3, 2'd0, 2'd1, 4'd2, 5, 1);
    check("bp_or", last_data, 13);
    check("bp_orf", last_flags, 3'b001);

    do_instr(4'hC, 2'd1, 2'd1, 4'd2, 0, 0);
    check("ill_err", last_err, 1);
    check("ill_data", last_data, 0);
    check("ill_flags", last_flags, 3'b001);
    do_instr(4'hB, 2'd2, 2'd1, 4'd0, 0, 0);
    check("mov_r1", last_data, 5);
    check("mov_err", last_err, 0);
    check("mov_flags", last_flags, 3'b001);

    do_instr(4'hA, 2'd3, 2'd0, 4'd2, 0, 0);
    do_instr(4'h6, 2'd0, 2'd1, 4'd3, 0, 0);
    check("shl", last_data, 4);
    do_instr(4'h7, 2'd0, 2'd2, 4'd2, 0, 0);
    check("shr_sat", last_data, 0);
    check("shr_z", last_flags, 3'b010);
    do_instr(4'h0, 2'd1, 2'd1, 4'd1, 0, 0);
    check("raw_old", last_data, 10);
    do_instr(4'h8, 2'd0, 2'd1, 4'd2, 0, 0);
    check("xor", last_data, 15);
    do_instr(4'h5, 2'd0, 2'd1, 4'd2, 2, 0);
    do_instr(4'h4, 2'd0, 2'd2, 4'd0, 0, 0);
    do_instr(4'h9, 2'd0, 2'd1, 4'd2, 1, 0);

    // Abort an ADD r3 while it is in ISSUE.
    wait_ready();
    instr       = {4'h0, 2'd3, 2'd1, 4'd2};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("abort_issue", alu_sel, 4'h0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_valid", res_valid, 0);
    check("abort_sel", alu_sel, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle", instr_ready, 1);
    check("abort_novld", res_valid, 0);
    do_instr(4'hB, 2'd0, 2'd3, 4'd0, 0, 0);
    check("abort_r3", last_data, 0);
    check("abort_flags", last_flags, 3'b000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
